// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package memory_controller_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] IO_ADDR_LO = 32'h0003_0000;
  localparam logic [ADDR_W-1:0] IO_ADDR_HI = 32'h0003_0007;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_FETCH = 2'd1,
    MC_LOAD  = 2'd2,
    MC_STORE = 2'd3
  } mc_status_t;

  typedef enum logic {
    OPTYPE_LOAD  = 1'b0,
    OPTYPE_STORE = 1'b1
  } op_t;

  // Request length code to byte count; the unused code 00 is treated as one byte.
  function automatic logic [CNT_W-1:0] len_bytes(input logic [LEN_W-1:0] len);
    case (len)
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic is_io(input logic [ADDR_W-1:0] addr);
    return (addr >= IO_ADDR_LO) && (addr <= IO_ADDR_HI);
  endfunction

endpackage

// File: rtl/memory_controller.sv
// Arbitrates IF fetches and LSB loads/stores onto a byte-wide synchronous RAM/IO bus,
// serialising each request into little-endian byte accesses.
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              if_to_mc_ready,
  input  logic [ADDR_W-1:0] if_to_mc_addr,
  output logic              mc_to_if_done,
  output logic [DATA_W-1:0] mc_to_if_inst,
  input  logic              lsb_to_mc_ready,
  input  logic [LEN_W-1:0]  lsb_to_mc_len,
  input  op_t               lsb_to_mc_opType,
  input  logic [ADDR_W-1:0] lsb_to_mc_addr,
  input  logic [DATA_W-1:0] lsb_to_mc_data,
  output logic              mc_valid,
  output logic              mc_to_lsb_ld_done,
  output logic              mc_to_lsb_st_done,
  output logic [DATA_W-1:0] mc_to_lsb_result,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  mc_status_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_n;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] data;
  logic              wr_q;
  logic              clr_seen;
  logic              stall_c;
  logic [DATA_W-1:0] asm_c;

  // A full UART buffer blocks writes into the IO window; the write is retried every cycle.
  assign stall_c = (state == MC_STORE) && io_buffer_full && is_io(mem_a);
  assign mem_wr  = wr_q && rdy_in && !stall_c;

  // mem_din at the edge with cnt=k carries byte k-1 (address issued two edges earlier).
  always_comb begin
    asm_c = data;
    case (cnt)
      3'd1:    asm_c[7:0]   = mem_din;
      3'd2:    asm_c[15:8]  = mem_din;
      3'd3:    asm_c[23:16] = mem_din;
      3'd4:    asm_c[31:24] = mem_din;
      default: asm_c = data;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= MC_IDLE;
      cnt               <= '0;
      len_n             <= '0;
      base              <= '0;
      data              <= '0;
      wr_q              <= 1'b0;
      clr_seen          <= 1'b0;
      mem_a             <= '0;
      mem_dout          <= '0;
      mc_valid          <= 1'b0;
      mc_to_lsb_ld_done <= 1'b0;
      mc_to_lsb_st_done <= 1'b0;
      mc_to_lsb_result  <= '0;
      mc_to_if_done     <= 1'b0;
      mc_to_if_inst     <= '0;
    end else if (rdy_in) begin
      mc_valid          <= 1'b0;
      mc_to_lsb_ld_done <= 1'b0;
      mc_to_lsb_st_done <= 1'b0;
      mc_to_if_done     <= 1'b0;
      case (state)
        MC_IDLE: begin
          if (!clr_in) begin
            if (lsb_to_mc_ready) begin
              base     <= lsb_to_mc_addr;
              mem_a    <= lsb_to_mc_addr;
              len_n    <= len_bytes(lsb_to_mc_len);
              cnt      <= '0;
              clr_seen <= 1'b0;
              mc_valid <= 1'b1;
              if (lsb_to_mc_opType == OPTYPE_STORE) begin
                state    <= MC_STORE;
                data     <= lsb_to_mc_data;
                mem_dout <= lsb_to_mc_data[7:0];
                wr_q     <= 1'b1;
              end else begin
                state <= MC_LOAD;
                data  <= '0;
              end
            end else if (if_to_mc_ready) begin
              base  <= if_to_mc_addr;
              mem_a <= if_to_mc_addr;
              len_n <= 3'd4;
              cnt   <= '0;
              data  <= '0;
              state <= MC_FETCH;
            end
          end
        end
        MC_FETCH, MC_LOAD: begin
          if (clr_in) begin
            state <= MC_IDLE;
            cnt   <= '0;
          end else if (cnt == len_n) begin
            state <= MC_IDLE;
            cnt   <= '0;
            data  <= asm_c;
            if (state == MC_FETCH) begin
              mc_to_if_done <= 1'b1;
              mc_to_if_inst <= asm_c;
            end else begin
              mc_to_lsb_ld_done <= 1'b1;
              mc_to_lsb_result  <= asm_c;
            end
          end else begin
            data <= asm_c;
            cnt  <= cnt + 3'd1;
            if ((cnt + 3'd1) < len_n) mem_a <= base + 32'(cnt + 3'd1);
          end
        end
        MC_STORE: begin
          // Accepted stores are committed: a flush only hides the completion pulse.
          if (clr_in) clr_seen <= 1'b1;
          if (!stall_c) begin
            if (cnt == (len_n - 3'd1)) begin
              state             <= MC_IDLE;
              cnt               <= '0;
              wr_q              <= 1'b0;
              mc_to_lsb_st_done <= !(clr_seen || clr_in);
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= base + 32'(cnt + 3'd1);
              data     <= data >> 8;
              mem_dout <= data[15:8];
            end
          end
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_controller.md
# memory_controller

Single-port arbiter between instruction fetch (IF) and the LoadStoreBuffer (LSB) and the byte-wide synchronous RAM/IO bus. It sits directly downstream of the LSB and consumes its `lsb_to_mc_*` requests. Each request is serialised into 1–4 byte accesses, little-endian. The block returns a `mc_to_lsb_ld_done`/`mc_to_lsb_st_done` pulse to the LSB, or a 32-bit instruction to IF.

## Interface
- Parameters: none. Widths come from `def.v`: `ADDR_TYPE`/`DATA_TYPE` 32 b, `LEN_TYPE` 2 b, `OP_TYPE`.
- Clocking and reset: one clock; reset is synchronous and active-high (`clk_in`, `rst_in`).

Ports:
- `clk_in`  in  1  clock
- `rst_in`  in  1  synchronous active-high reset
- `rdy_in`  in  1  global enable; low = freeze
- `clr_in`  in  1  misprediction flush
- `if_to_mc_ready`  in  1  fetch request
- `if_to_mc_addr`  in  32  fetch address
- `mc_to_if_done`  out  1  one-cycle pulse, instruction valid
- `mc_to_if_inst`  out  32  fetched word
- `lsb_to_mc_ready`  in  1  LSB request (level, held until `mc_valid`)
- `lsb_to_mc_len`  in  2  01=1 B, 10=2 B, 11=4 B
- `lsb_to_mc_opType`  in  `OP_TYPE`  `OPTYPE_LOAD` / `OPTYPE_STORE`
- `lsb_to_mc_addr`  in  32  byte address
- `lsb_to_mc_data`  in  32  store data
- `mc_valid`  out  1  one-cycle pulse: LSB request accepted
- `mc_to_lsb_ld_done`  out  1  one-cycle pulse
- `mc_to_lsb_st_done`  out  1  one-cycle pulse
- `mc_to_lsb_result`  out  32  raw bytes, zero-filled above len
- `mem_din`  in  8  RAM read byte, valid the cycle after its address
- `mem_dout`  out  8  write byte
- `mem_a`  out  32  byte address
- `mem_wr`  out  1  1 = write
- `io_buffer_full`  in  1  UART buffer full

## Operation
- States: `IDLE`, `FETCH`, `LOAD`, `STORE`.
- Byte counter `cnt` (0..len-1).
- Address register, 32-bit data shift/assembly register.
- `IDLE`:
  - `lsb_to_mc_ready` has priority over `if_to_mc_ready`.
  - Accepting an LSB request latches addr/data/len/op, pulses `mc_valid`, and enters `LOAD`/`STORE`.
  - Accepting IF latches the address, sets len=4, and enters `FETCH`.
- `LOAD`/`FETCH`:
  - Drive `mem_a` = base+cnt for cnt=0..n-1 on consecutive cycles.
  - Byte arriving for cnt k goes to bits [8k+7:8k].
  - After the last byte: pulse done, return to `IDLE`.
- `STORE`:
  - Drive `mem_wr`=1, `mem_a`=base+k, `mem_dout`=data[8k+7:8k] for k=0..n-1.
  - Then pulse `mc_to_lsb_st_done` and return to `IDLE`.
- IO stall: in `STORE`, if `io_buffer_full`=1 and the current address is in 0x30000–0x30007, hold `cnt`, force `mem_wr`=0, and retry each cycle.
- `clr_in`:
  - Aborts `FETCH` and `LOAD` immediately (next state `IDLE`, no done pulse).
  - A `STORE` already accepted runs to completion (it is committed), but its `st_done` is suppressed.
  - Requests are not accepted in the clr cycle.
- `rdy_in`=0: all registers hold. `mem_wr` is combinationally gated to 0. The held access is reissued when `rdy_in` returns.
- Address arithmetic is 32-bit wrap; unaligned accesses are legal.

## Timing
- Reset values: all outputs 0; state `IDLE`; `cnt` 0; `mc_to_if_inst`/`mc_to_lsb_result` 0.
- Counting from the edge that samples the request, E0:
  - `mc_valid` is high in cycle 1.
  - Address bytes are on `mem_a` in cycles 1..n.
  - Data is captured from `mem_din` in cycles 2..n+1.
- Load/fetch done pulse is high in cycle n+2 (fetch: cycle 6).
- Store writes occur in cycles 1..n; `st_done` is high in cycle n+1.
- `IDLE` is re-entered with the done pulse. A new request may be sampled at the end of the done cycle (one-cycle turnaround).
- A request held high while busy is not re-accepted. The LSB drops `ready` after `mc_valid`.
- Reset mid-transaction: abort all, including stores; no pulses.

## Structure
- In `def.v`:
  - `LEN_TYPE`, `OP_TYPE`, `OPTYPE_LOAD`, `OPTYPE_STORE`.
  - `MC_STATUS_TYPE` and the four state encodings.
  - `IO_ADDR_LO` = 0x30000, `IO_ADDR_HI` = 0x30007.
- Single module, no sub-module; byte lane select is an inline case on `cnt`.

## Test plan
- RAM preloaded with bytes 0x78,0x56,0x34,0x12 at 0x100; LW request at 0x100 -> `mc_valid` in cycle 1, `mem_a` 0x100..0x103, `ld_done` in cycle 6, result 0x12345678.
- LB at 0x101 (len 01) -> result 0x00000056, done in cycle 3.
- SH of 0xDEADBEEF to 0x200 -> writes 0xEF@0x200, 0xBE@0x201, `st_done` in cycle 3. A following LW at 0x200 reads 0x????BEEF.
- IF and LSB requests asserted in the same cycle -> LSB served first. IF `done` follows with the correct instruction; no lost request.
- SB to 0x30000 with `io_buffer_full` high for 5 cycles -> no `mem_wr` during the stall; a single write after release; `st_done` once.
- `clr_in` during an LW (cycle 3) -> no `ld_done`, `IDLE` next. `clr_in` during an SW -> all 4 bytes written, no `st_done`. `rdy_in` low for 3 cycles mid-load -> same result, delayed by 3.
